grf_regfile: RTL and testbench

- General-purpose register file for the single-cycle MIPS-style CPU: 2^ADDR_W registers, DATA_W bits wide.
- Two asynchronous (combinational) read ports (A, B) and one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between instruction decode (register specifiers) and the ALU/writeback mux.

---
 rtl/grf_regfile.sv | 89 ++++++++
 tb/tb_grf_regfile.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/grf_regfile.sv
// grf_regfile: general-purpose register file for the single-cycle CPU.
// 2^ADDR_W registers of DATA_W bits, two combinational read ports (A, B)
// and one synchronous write port. Register 0 always reads zero.
// Optional build macro: GRF_WRITE_BYPASS_EN adds write-through forwarding
// so a read of the register being written returns busW in the same cycle.
module grf_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RW,
    input  logic [DATA_W-1:0] busW,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              wr_en;

    // Writes to register 0 are dropped here so it never leaves zero.
    assign wr_en = RegWrite && (RW != '0);

    // Next-state of the array: only the addressed entry changes on a write.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[RW] = busW;
        end
        regs_d[0] = '0;
    end

    // Register array; asynchronous active-low clear overrides any write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef GRF_WRITE_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    // Forward the in-flight write to a port reading the same register.
    always_comb begin
        fwd_a = wr_en && reset && (RA == RW);
        fwd_b = wr_en && reset && (RB == RW);
    end

    // Read ports with write-through; register 0 and reset force zero.
    always_comb begin
        busA = '0;
        busB = '0;
        if (reset && (RA != '0)) begin
            busA = fwd_a ? busW : regs_q[RA];
        end
        if (reset && (RB != '0)) begin
            busB = fwd_b ? busW : regs_q[RB];
        end
    end
`else
    // Read ports show stored contents; register 0 and reset force zero.
    always_comb begin
        busA = '0;
        busB = '0;
        if (reset && (RA != '0)) begin
            busA = regs_q[RA];
        end
        if (reset && (RB != '0)) begin
            busB = regs_q[RB];
        end
    end
`endif

endmodule

// File: tb/tb_grf_regfile.sv
// Self-checking bench for grf_regfile: scoreboard of expected bus values
// built from a behavioural model of the register array.
module tb_grf_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic [AW-1:0] RA, RB, RW;
    logic [DW-1:0] busW;
    logic          RegWrite;
    logic [DW-1:0] busA, busB;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic [DW-1:0] model [32];

    grf_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .RA(RA), .RB(RB), .RW(RW),
        .busW(busW), .RegWrite(RegWrite), .busA(busA), .busB(busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        exp_t x;
        x.ra = ra;
        x.rb = rb;
        x.a  = (ra == 0) ? '0 : model[ra];
        x.b  = (rb == 0) ? '0 : model[rb];
        return x;
    endfunction

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        RW = a; busW = d; RegWrite = 1'b1;
        @(negedge clk);
        RegWrite = 1'b0;
        if (a != 0 && reset) model[a] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        checks++;
        if (busA !== 32'h0) begin errors++; $display("FAIL reset_init busA=%h expected=%h", busA, 32'h0); end
        @(negedge clk);
        reset = 1'b1;
        write_reg(5'd1, 32'h1111_0001);
        write_reg(5'd12, 32'h1212_000C);
        write_reg(5'd31, 32'hF00D_001F);
        sb.push_back(mk(5'd1, 5'd12));
        sb.push_back(mk(5'd31, 5'd1));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            RA = e.ra; RB = e.rb; #1;
            checks += 2;
            if (busA !== e.a) begin errors++; $display("FAIL preload busA RA=%0d got=%h expected=%h", e.ra, busA, e.a); end
            if (busB !== e.b) begin errors++; $display("FAIL preload busB RB=%0d got=%h expected=%h", e.rb, busB, e.b); end
        end
        // assert reset mid-cycle with no clock edge in between
        @(posedge clk);
        RA = 5'd1; RB = 5'd12;
        #2 reset = 1'b0;
        #1;
        checks += 2;
        if (busA !== 32'h0) begin errors++; $display("FAIL reset_async busA got=%h expected=%h", busA, 32'h0); end
        if (busB !== 32'h0) begin errors++; $display("FAIL reset_async busB got=%h expected=%h", busB, 32'h0); end
        for (int i = 0; i < 32; i++) model[i] = '0;
        // attempted write while reset held must be ignored
        @(negedge clk);
        RW = 5'd31; busW = 32'hBAD0_BAD0; RegWrite = 1'b1;
        RA = 5'd31; RB = 5'd12;
        repeat (3) begin
            @(posedge clk); #1;
            checks += 2;
            if (busA !== 32'h0) begin errors++; $display("FAIL reset_hold busA got=%h expected=%h", busA, 32'h0); end
            if (busB !== 32'h0) begin errors++; $display("FAIL reset_hold busB got=%h expected=%h", busB, 32'h0); end
        end
        @(negedge clk);
        RegWrite = 1'b0;
        reset = 1'b1;
        sb.push_back(mk(5'd31, 5'd1));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            RA = e.ra; RB = e.rb; #1;
            checks += 2;
            if (busA !== e.a) begin errors++; $display("FAIL reset_release busA got=%h expected=%h", busA, e.a); end
            if (busB !== e.b) begin errors++; $display("FAIL reset_release busB got=%h expected=%h", busB, e.b); end
        end
    endtask

    task automatic test_basic();
        write_reg(5'd1, 32'd1234);
        sb.push_back(mk(5'd1, 5'd12));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            RA = e.ra; RB = e.rb; #1;
            checks += 2;
            if (busA !== e.a) begin errors++; $display("FAIL basic busA got=%h expected=%h", busA, e.a); end
            if (busB !== e.b) begin errors++; $display("FAIL basic busB got=%h expected=%h", busB, e.b); end
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        RA = 5'd0; RB = 5'd0;
        RW = 5'd0; busW = 32'd1234; RegWrite = 1'b1;
        #1;
        checks += 2;
        if (busA !== 32'h0) begin errors++; $display("FAIL zero_fwd busA got=%h expected=%h", busA, 32'h0); end
        if (busB !== 32'h0) begin errors++; $display("FAIL zero_fwd busB got=%h expected=%h", busB, 32'h0); end
        @(negedge clk);
        RegWrite = 1'b0;
        sb.push_back(mk(5'd0, 5'd0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            RA = e.ra; RB = e.rb; #1;
            checks += 2;
            if (busA !== e.a) begin errors++; $display("FAIL zero_reg busA got=%h expected=%h", busA, e.a); end
            if (busB !== e.b) begin errors++; $display("FAIL zero_reg busB got=%h expected=%h", busB, e.b); end
        end
    endtask

    task automatic test_write_disable();
        @(negedge clk);
        RW = 5'd13; busW = 32'hDEAD_BEEF; RegWrite = 1'b0;
        RB = 5'd13; RA = 5'd1;
        @(posedge clk); #1;
        sb.push_back(mk(5'd1, 5'd13));
        e = sb.pop_front();
        checks += 2;
        if (busA !== e.a) begin errors++; $display("FAIL wr_disable busA got=%h expected=%h", busA, e.a); end
        if (busB !== e.b) begin errors++; $display("FAIL wr_disable busB got=%h expected=%h", busB, e.b); end
        write_reg(5'd13, 32'hDEAD_BEEF);
        sb.push_back(mk(5'd1, 5'd13));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            RA = e.ra; RB = e.rb; #1;
            checks += 2;
            if (busA !== e.a) begin errors++; $display("FAIL wr_enable busA got=%h expected=%h", busA, e.a); end
            if (busB !== e.b) begin errors++; $display("FAIL wr_enable busB got=%h expected=%h", busB, e.b); end
        end
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] pre;
        write_reg(5'd5, 32'd7);
        @(negedge clk);
        RA = 5'd5; RB = 5'd1;
        RW = 5'd5; busW = 32'd9; RegWrite = 1'b1;
`ifdef GRF_WRITE_BYPASS_EN
        pre = 32'd9;
`else
        pre = 32'd7;
`endif
        #1;
        checks += 2;
        if (busA !== pre) begin errors++; $display("FAIL same_cycle_pre busA got=%h expected=%h", busA, pre); end
        if (busB !== model[1]) begin errors++; $display("FAIL same_cycle_pre busB got=%h expected=%h", busB, model[1]); end
        model[5] = 32'd9;
        @(posedge clk); #1;
        checks++;
        if (busA !== 32'd9) begin errors++; $display("FAIL same_cycle_post busA got=%h expected=%h", busA, 32'd9); end
        @(negedge clk);
        RegWrite = 1'b0;
    endtask

    task automatic test_sweep();
        for (int k = 1; k < 32; k++) write_reg(k[AW-1:0], k * 32'h0101_0101);
        for (int k = 1; k < 32; k++) sb.push_back(mk(k[AW-1:0], 5'(32 - k)));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            RA = e.ra; RB = e.rb; #1;
            checks += 2;
            if (busA !== e.a) begin errors++; $display("FAIL sweep busA RA=%0d got=%h expected=%h", e.ra, busA, e.a); end
            if (busB !== e.b) begin errors++; $display("FAIL sweep busB RB=%0d got=%h expected=%h", e.rb, busB, e.b); end
        end
        @(negedge clk);
        RA = 5'd16; RB = 5'd16; #1;
        checks++;
        if (busA !== busB || busA !== 32'h1010_1010) begin
            errors++;
            $display("FAIL same_addr busA=%h busB=%h expected=%h", busA, busB, 32'h1010_1010);
        end
    endtask

    initial begin
        reset = 1'b1; RA = '0; RB = '0; RW = '0; busW = '0; RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        test_reset();
        test_basic();
        test_zero_reg();
        test_write_disable();
        test_same_cycle();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
